aes_core_scheduler: RTL
=======================

// Module: aes_core_scheduler
// PURPOSE
//  Shares one aesmodule core between two requesters (port 0, port 1).
//  Arbitrates round-robin, latches the winner's block and direction, starts the core
//  by pulsing its reset input, waits for ready, and returns the result.
//  Sits between the AES core and the upstream block producers (ECB/CBC front ends).
// PARAMETERS
//  DATA_W   128  block width; must match aesmodule in/out
//  TIMEOUT  64   max cycles in WAIT before an aborted response (error set)
//  TCNT_W   7    width of the wait counter; must satisfy 2**TCNT_W > TIMEOUT
// PORTS
//  clk          in   1       single clock; all logic on posedge
//  reset        in   1       synchronous, active-high
//  reqN_valid   in   1       (N=0,1) request holds a block
//  reqN_ready   out  1       one-cycle accept pulse; block taken when valid&ready
//  reqN_data    in   DATA_W  plaintext or ciphertext block
//  reqN_decr    in   1       1 = decrypt, 0 = encrypt
//  respN_valid  out  1       result held for requester N
//  respN_ready  in   1       requester consumes result when valid&ready
//  respN_data   out  DATA_W  core result (zero on error)
//  respN_err    out  1       1 = core timed out
//  core_in      out  DATA_W  to aesmodule.in; held stable from LAUNCH to capture
//  core_decr    out  1       to aesmodule.decr; held like core_in
//  core_start   out  1       to aesmodule.reset; one-cycle high pulse
//  core_out     in   DATA_W  from aesmodule.out
//  core_ready   in   1       from aesmodule.ready
//  busy         out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state=IDLE; last_grant=1 (port 0 wins first tie); counter=0.
//  Reset mid-operation aborts the job silently: no response, request not re-accepted.
//  FSM: IDLE -> LAUNCH -> BLANK -> WAIT -> RESP -> IDLE.
//  - IDLE: if either valid, grant by round-robin (both valid -> port != last_grant).
//    Same cycle: reqG_ready=1, latch data/decr into core_in/core_decr, set last_grant=G.
//  - LAUNCH: core_start=1 for exactly this cycle.
//  - BLANK: one cycle; core_ready ignored (stale ready from previous job).
//  - WAIT: counter increments each cycle. If core_ready=1, capture core_out into
//    respG_data, err=0, go RESP. Else, when counter==TIMEOUT-1: data=0, err=1, go RESP.
//    core_ready wins if it coincides with the timeout cycle.
//  - RESP: respG_valid=1 with data/err stable until respG_ready; on handshake, valid
//    drops next cycle and FSM returns to IDLE. No new grant in the handshake cycle.
//  - Only one job in flight; the other port's reqN_ready stays 0 until IDLE.
//  - respN_* of the non-granted port stay 0. Counter clears on entry to WAIT.
//  - Minimum turnaround: request accept to respN_valid = 3 + core latency cycles.
//  - Valid dropped before accept: no effect; arbiter samples valid only in IDLE.
// STRUCTURE
//  Package aes_sched_pkg: DATA_W, state enum (IDLE, LAUNCH, BLANK, WAIT, RESP),
//    TIMEOUT default.
//  Sub-module rr_arbiter_2: 2-way round-robin grant from valids + last_grant,
//    combinational grant, registered pointer update on accept.
//  Top: FSM, data/decr latch, result register, timeout counter.
// TESTING (bench instantiates a real aesmodule with the fixed test key)
//  1 req0 enc 3243f6a8_885a308d_313198a2_e0370734 -> resp0_data
//    3925841d_02dc09fb_dc118597_196a0b32, err=0; core_start high exactly 1 cycle.
//  2 req1 decr 3925841d_02dc09fb_dc118597_196a0b32 -> resp1_data
//    3243f6a8_885a308d_313198a2_e0370734; resp0_valid stays 0.
//  3 both valid in the same cycle, three rounds -> grants 0,1,0; each response on its own port.
//  4 stub core with ready held low -> resp_err=1, data=0 after exactly TIMEOUT WAIT cycles.
//  5 resp0_ready held low 10 cycles -> resp0_valid/data stable; req1 not accepted until after handshake.
//  6 reset asserted during WAIT -> all outputs 0 next cycle; fresh req0 completes normally.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// ---------------------------------------------------------------------------
// aes_sched_pkg
// Shared definitions for the AES core scheduler: default block width,
// default WAIT timeout and counter width, and the scheduler state encoding.
// No ports; imported by aes_core_scheduler and rr_arbiter_2.
// ---------------------------------------------------------------------------
package aes_sched_pkg;

    // Block width of the shared aesmodule (in/out buses).
    localparam int DEF_DATA_W  = 128;

    // Cycles spent in WAIT before the job is answered with an error.
    localparam int DEF_TIMEOUT = 64;

    // Wait counter width; 2**DEF_TCNT_W must exceed DEF_TIMEOUT.
    localparam int DEF_TCNT_W  = 7;

    // One job in flight at a time, walked through these states in order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BLANK  = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-way round-robin arbiter. The grant is combinational from the valids and
// the remembered last winner; the last-winner pointer only moves when the
// caller reports that the grant was actually taken (accept).
//
// Ports
//   clk        in   1   clock, posedge
//   reset      in   1   synchronous, active-high; last winner forced to 1
//                       so that port 0 wins the first tie
//   valid      in   2   request valids, bit N = port N
//   accept     in   1   current grant is being consumed this cycle
//   grant_any  out  1   at least one port is requesting
//   grant      out  1   index of the winning port (meaningful with grant_any)
// ---------------------------------------------------------------------------
module rr_arbiter_2
    import aes_sched_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant_any,
    output logic       grant
);

    logic last_grant;

    // On a tie the port that did not win last time gets the grant;
    // a lone requester always wins regardless of history.
    always_comb begin
        grant_any = |valid;
        grant     = 1'b0;
        if (valid == 2'b11) begin
            grant = ~last_grant;
        end else if (valid[1]) begin
            grant = 1'b1;
        end
    end

    // Pointer only advances on a real accept so an unserved request
    // does not lose its turn.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/aes_core_scheduler.sv
// ---------------------------------------------------------------------------
// aes_core_scheduler
// Shares one aesmodule core between two requesters. A round-robin arbiter
// picks a port while idle, the winning block and direction are latched onto
// the core inputs, the core is kicked with a one-cycle pulse on its reset
// input, and the scheduler waits for the core's ready (bounded by TIMEOUT).
// The result, or zero plus an error flag on timeout, is held on the winning
// port's response bus until that port takes it.
//
// Parameters
//   DATA_W   block width, must match the core
//   TIMEOUT  cycles allowed in WAIT before an error response
//   TCNT_W   wait counter width, 2**TCNT_W > TIMEOUT
//
// Ports
//   clk, reset                 clock (posedge) and synchronous active-high reset
//   req{0,1}_valid/ready       request handshake; ready is a one-cycle accept
//   req{0,1}_data/decr         block and direction (1 = decrypt)
//   resp{0,1}_valid/ready      response handshake; valid held until ready
//   resp{0,1}_data/err         result (zero on error), err = core timed out
//   core_in/core_decr          to the core, stable from launch to capture
//   core_start                 to the core's reset input, one-cycle pulse
//   core_out/core_ready        from the core
//   busy                       a job is in progress (state not IDLE)
// ---------------------------------------------------------------------------
module aes_core_scheduler
    import aes_sched_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TCNT_W  = DEF_TCNT_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_decr,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_decr,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic [DATA_W-1:0] resp0_data,
    output logic              resp0_err,

    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [DATA_W-1:0] resp1_data,
    output logic              resp1_err,

    output logic [DATA_W-1:0] core_in,
    output logic              core_decr,
    output logic              core_start,
    input  logic [DATA_W-1:0] core_out,
    input  logic              core_ready,

    output logic              busy
);

    sched_state_t      state;
    sched_state_t      state_next;

    logic              sel;
    logic [DATA_W-1:0] res_data;
    logic              res_err;
    logic [TCNT_W-1:0] wait_cnt;

    logic [1:0]        arb_valid;
    logic              grant_any;
    logic              grant;
    logic              accept;
    logic              in_resp;
    logic              resp_hs;
    logic              timeout_hit;

    // The arbiter only ever sees requests while idle and out of reset, so a
    // valid that comes and goes during a job is never noticed, and nothing
    // can be accepted in the cycle reset is held.
    always_comb begin
        arb_valid = 2'b00;
        if ((state == IDLE) && !reset) begin
            arb_valid = {req1_valid, req0_valid};
        end
    end

    rr_arbiter_2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (arb_valid),
        .accept    (accept),
        .grant_any (grant_any),
        .grant     (grant)
    );

    assign accept      = grant_any;
    assign in_resp     = (state == RESP);
    assign resp_hs     = in_resp && (sel ? resp1_ready : resp0_ready);
    assign timeout_hit = (wait_cnt == TCNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. BLANK exists only to let a ready left over from the
    // previous job clear before WAIT starts listening. In WAIT a ready that
    // lands on the last allowed cycle still counts as success.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = BLANK;
            end
            BLANK: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (core_ready || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_hs) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: winner latch, core operands, wait counter and the
    // result holding register. The core operands stay put after capture
    // until the next accept overwrites them.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel       <= 1'b0;
            core_in   <= '0;
            core_decr <= 1'b0;
            wait_cnt  <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sel       <= grant;
                        core_in   <= grant ? req1_data : req0_data;
                        core_decr <= grant ? req1_decr : req0_decr;
                    end
                end
                BLANK: begin
                    wait_cnt <= '0;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + TCNT_W'(1);
                    if (core_ready) begin
                        res_data <= core_out;
                        res_err  <= 1'b0;
                    end else if (timeout_hit) begin
                        res_data <= '0;
                        res_err  <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Request accepts are pure functions of the arbiter grant; the core kick
    // and busy flag decode straight from state.
    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        core_start = (state == LAUNCH);
        busy       = (state != IDLE);
    end

    // Only the port that owns the current job ever sees a non-zero response.
    always_comb begin
        resp0_valid = in_resp && !sel;
        resp1_valid = in_resp && sel;
        resp0_data  = '0;
        resp0_err   = 1'b0;
        resp1_data  = '0;
        resp1_err   = 1'b0;
        if (resp0_valid) begin
            resp0_data = res_data;
            resp0_err  = res_err;
        end
        if (resp1_valid) begin
            resp1_data = res_data;
            resp1_err  = res_err;
        end
    end

endmodule
